// File: rtl/rv_control.sv
// Multi-cycle RV32I control unit: fetches over a req/valid handshake, decodes OP/OP-IMM ALU ops, owns the PC.
// Optional retired-instruction counter enabled by defining RV_CONTROL_RETIRE_CNT_EN.
module rv_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs_1,
  output logic [4:0]  rs_2,
  output logic [4:0]  rd_0,
  output logic [2:0]  alu_control,
  output logic        sel_imm,
  output logic [31:0] imm,
  output logic        write_rb,
  output logic [31:0] pc,
  output logic        illegal
`ifdef RV_CONTROL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_TRAP      = 3'd4
  } state_t;

  state_t state, next_state;
  logic [XLEN-1:0] ir;

  logic            dec_legal;
  logic [2:0]      dec_alu;
  logic            dec_sel_imm;

  logic            imem_req_nxt;
  logic            write_rb_nxt;
  logic            illegal_nxt;
  logic            load_ctrl;
  logic            load_ir;
  logic [XLEN-1:0] pc_nxt;

  // Instruction decode of the latched word
  always_comb begin
    dec_legal   = 1'b0;
    dec_alu     = ALU_ADD;
    dec_sel_imm = 1'b0;
    case (ir[6:0])
      OPC_OP: begin
        case ({ir[31:25], ir[14:12]})
          10'b0000000_000: begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
          10'b0100000_000: begin dec_legal = 1'b1; dec_alu = ALU_SUB; end
          10'b0000000_111: begin dec_legal = 1'b1; dec_alu = ALU_AND; end
          10'b0000000_110: begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
          10'b0000000_010: begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        dec_sel_imm = 1'b1;
        case (ir[14:12])
          3'b000: begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
          3'b111: begin dec_legal = 1'b1; dec_alu = ALU_AND; end
          3'b110: begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
          3'b010: begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (imem_valid) next_state = S_DECODE;
      S_DECODE:    next_state = dec_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = S_FETCH;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_FETCH;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    imem_req_nxt = (next_state == S_FETCH);
    write_rb_nxt = (next_state == S_WRITEBACK);
    illegal_nxt  = illegal | (next_state == S_TRAP);
    load_ir      = (state == S_FETCH) && imem_valid;
    load_ctrl    = (state == S_DECODE) && dec_legal;
    pc_nxt       = (state == S_WRITEBACK) ? pc + XLEN'(4) : pc;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      ir          <= NOP_INSTR;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      write_rb    <= 1'b0;
      illegal     <= 1'b0;
      rs_1        <= 5'd0;
      rs_2        <= 5'd0;
      rd_0        <= 5'd0;
      alu_control <= 3'd0;
      sel_imm     <= 1'b0;
      imm         <= '0;
    end else begin
      state    <= next_state;
      pc       <= pc_nxt;
      imem_req <= imem_req_nxt;
      write_rb <= write_rb_nxt;
      illegal  <= illegal_nxt;
      if (load_ir) ir <= imem_rdata;
      if (load_ctrl) begin
        rs_1        <= ir[19:15];
        rs_2        <= ir[24:20];
        rd_0        <= ir[11:7];
        alu_control <= dec_alu;
        sel_imm     <= dec_sel_imm;
        imm         <= {{20{ir[31]}}, ir[31:20]};
      end
    end
  end

  assign imem_addr = pc;

`ifdef RV_CONTROL_RETIRE_CNT_EN
  // Counts completed writebacks; a trapped core never reaches WRITEBACK
  always_ff @(posedge clk) begin
    if (rst) retired <= '0;
    else if (state == S_WRITEBACK) retired <= retired + XLEN'(1);
  end
`endif

endmodule

// File: tb/tb_rv_control.sv
// Self-checking bench for rv_control: directed test-plan steps plus random instruction streams.
module tb_rv_control;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  rs_1, rs_2, rd_0;
  logic [2:0]  alu_control;
  logic        sel_imm;
  logic [31:0] imm;
  logic        write_rb;
  logic [31:0] pc;
  logic        illegal;
`ifdef RV_CONTROL_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  rv_control #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rs_1(rs_1), .rs_2(rs_2), .rd_0(rd_0),
    .alu_control(alu_control), .sel_imm(sel_imm), .imm(imm),
    .write_rb(write_rb), .pc(pc), .illegal(illegal)
`ifdef RV_CONTROL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  // Reference ISA table: one row per supported mnemonic
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         is_imm;
    logic [2:0] alu;
  } op_t;
  op_t ops [9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] w, output bit legal,
                                output logic [2:0] alu, output bit use_imm);
    legal = 0; alu = 3'd0; use_imm = 0;
    for (int i = 0; i < 9; i++)
      if (w[6:0] == ops[i].opc && w[14:12] == ops[i].f3 &&
          (ops[i].is_imm || w[31:25] == ops[i].f7)) begin
        legal = 1; alu = ops[i].alu; use_imm = ops[i].is_imm;
      end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    repeat (n) step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_wrb", 32'(write_rb), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    check("rst_alu", 32'(alu_control), 32'd0);
`ifdef RV_CONTROL_RETIRE_CNT_EN
    check("rst_ret", retired, 32'd0);
`endif
    rst = 1'b0;
    imem_valid = 1'b0;
    step();
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, RST_PC);
    exp_pc = RST_PC;
    exp_ret = 32'd0;
  endtask

  // Runs one instruction from its first FETCH cycle; returns in the next FETCH cycle or in TRAP
  task automatic run_instr(input logic [31:0] w, input int waitn);
    bit legal, use_imm;
    logic [2:0] alu;
    model(w, legal, alu, use_imm);
    for (int k = 0; k < waitn; k++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_wrb", 32'(write_rb), 32'd0);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      step();
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_valid = 1'b1;
    imem_rdata = w;
    step();
    // Out-of-fetch valid/rdata traffic must be ignored
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    check("dec_req", 32'(imem_req), 32'd0);
    check("dec_wrb", 32'(write_rb), 32'd0);
    check("dec_ill", 32'(illegal), 32'd0);
    step();
    if (!legal) begin
      for (int k = 0; k < 4; k++) begin
        check("trap_ill", 32'(illegal), 32'd1);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_wrb", 32'(write_rb), 32'd0);
        check("trap_pc", pc, exp_pc);
`ifdef RV_CONTROL_RETIRE_CNT_EN
        check("trap_ret", retired, exp_ret);
`endif
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        step();
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      check(k == 0 ? "ex_wrb" : "wb_wrb", 32'(write_rb), k == 0 ? 32'd0 : 32'd1);
      check("ctl_rs1", 32'(rs_1), 32'(w[19:15]));
      if (!use_imm) check("ctl_rs2", 32'(rs_2), 32'(w[24:20]));
      check("ctl_rd", 32'(rd_0), 32'(w[11:7]));
      check("ctl_alu", 32'(alu_control), 32'(alu));
      check("ctl_sel", 32'(sel_imm), 32'(use_imm));
      if (use_imm) check("ctl_imm", imm, 32'($signed(w[31:20])));
      check("ex_req", 32'(imem_req), 32'd0);
      check("ex_pc", pc, exp_pc);
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step();
    end
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    check("nf_pc", pc, exp_pc);
    check("nf_req", 32'(imem_req), 32'd1);
    check("nf_wrb", 32'(write_rb), 32'd0);
    check("nf_ill", 32'(illegal), 32'd0);
`ifdef RV_CONTROL_RETIRE_CNT_EN
    check("nf_ret", retired, exp_ret);
`endif
  endtask

  initial begin
    logic [31:0] w;
    bit legal, use_imm;
    logic [2:0] alu;
    int idx;

    ops[0] = '{7'h33, 3'd0, 7'h00, 1'b0, 3'b010};  // ADD
    ops[1] = '{7'h33, 3'd0, 7'h20, 1'b0, 3'b110};  // SUB
    ops[2] = '{7'h33, 3'd7, 7'h00, 1'b0, 3'b000};  // AND
    ops[3] = '{7'h33, 3'd6, 7'h00, 1'b0, 3'b001};  // OR
    ops[4] = '{7'h33, 3'd2, 7'h00, 1'b0, 3'b111};  // SLT
    ops[5] = '{7'h13, 3'd0, 7'h00, 1'b1, 3'b010};  // ADDI
    ops[6] = '{7'h13, 3'd7, 7'h00, 1'b1, 3'b000};  // ANDI
    ops[7] = '{7'h13, 3'd6, 7'h00, 1'b1, 3'b001};  // ORI
    ops[8] = '{7'h13, 3'd2, 7'h00, 1'b1, 3'b111};  // SLTI

    rst = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    do_reset(2);

    run_instr(32'h002081B3, 0);  // ADD x3,x1,x2
    run_instr(32'h407302B3, 0);  // SUB x5,x6,x7
    run_instr(32'hFFB00093, 0);  // ADDI x1,x0,-5
    run_instr(32'h002081B3, 3);  // memory wait

    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 8));
      if (ops[idx].is_imm)
        w = {12'($urandom), 5'($urandom), ops[idx].f3, 5'($urandom), ops[idx].opc};
      else
        w = {ops[idx].f7, 5'($urandom), 5'($urandom), ops[idx].f3, 5'($urandom), ops[idx].opc};
      run_instr(w, int'($urandom_range(0, 3)));
    end

    run_instr(32'hFFFFFFFF, 1);
    do_reset(1);
    run_instr(32'h4020F1B3, 0);  // SUB encoding with funct3=111
    do_reset(1);
    run_instr(32'h00109093, 2);  // OP-IMM funct3=001 unsupported
    do_reset(1);

    for (int n = 0; n < 8; n++) begin
      w = $urandom;
      model(w, legal, alu, use_imm);
      run_instr(w, int'($urandom_range(0, 2)));
      if (!legal) do_reset(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_control.md
Name: rv_control

Overview:
- Multi-cycle control unit directly upstream of `datapath`.
- Fetches 32-bit RV32I instructions over a simple request/valid memory handshake and decodes R-type and I-type ALU instructions.
- Drives the datapath's register-bank read/write addresses, `alu_control`, immediate/operand select and `write_rb` strobe.
- Owns the program counter; raises a sticky trap on illegal encodings.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request, held high until imem_valid seen
- imem_addr  output  32  fetch address (= pc while imem_req high)
- imem_valid  input  1  imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction word
- rs_1  output  5  datapath read address A (instr[19:15])
- rs_2  output  5  datapath read address B (instr[24:20])
- rd_0  output  5  datapath write address (instr[11:7])
- alu_control  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- sel_imm  output  1  1 = ALU operand B from imm, 0 = from rs_2
- imm  output  32  sign-extended I-type immediate (instr[31:20])
- write_rb  output  1  one-cycle register-bank write strobe
- pc  output  32  current program counter
- illegal  output  1  sticky illegal-instruction flag

Behaviour:
- States: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- Reset: state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP).
  - All outputs 0 except imem_addr/pc=RESET_PC.
  - Reset overrides every state, including a pending fetch and TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On the cycle imem_valid=1, latch imem_rdata into ir and go to DECODE.
  - imem_req deasserts in DECODE.
  - imem_valid may arrive in the first FETCH cycle or any later cycle; no timeout.
  - imem_valid outside FETCH is ignored.
- DECODE: decode ir, then register all datapath controls. These hold stable through EXECUTE and WRITEBACK.
  - opcode 0110011 (OP), funct7/funct3:
    - 0000000/000 ADD→010
    - 0100000/000 SUB→110
    - 0000000/111 AND→000
    - 0000000/110 OR→001
    - 0000000/010 SLT→111
    - sel_imm=0
  - opcode 0010011 (OP-IMM), funct3:
    - 000 ADDI→010
    - 111 ANDI→000
    - 110 ORI→001
    - 010 SLTI→111
    - sel_imm=1
    - imm={{20{ir[31]}},ir[31:20]}
  - Any other opcode/funct combination: go to TRAP, illegal=1, no write.
  - Legal: go to EXECUTE.
- EXECUTE: one cycle for combinational regfile read + ALU settle; write_rb=0. Go to WRITEBACK.
- WRITEBACK:
  - write_rb=1 for exactly this cycle; asserted even when rd_0=0, since x0 is hardwired in datapath.
  - pc <= pc+4, wrapping modulo 2^32.
  - Go to FETCH.
- TRAP: terminal.
  - illegal=1, imem_req=0, write_rb=0, pc frozen at the faulting address.
  - Exit only via rst.
- Latency: 4 cycles per instruction when imem_valid is returned in the first FETCH cycle, plus N cycles per memory wait.
- write_rb is never high outside WRITEBACK.

Optional Feature:
- Macro: RV_CONTROL_RETIRE_CNT_EN
- Defined:
  - Adds output port `retired` (32) counting WRITEBACK cycles.
  - Resets to 0, wraps at 2^32, does not increment in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst 2 cycles → pc=0, imem_req=0 during reset then 1 in the first post-reset cycle, write_rb=0, illegal=0, alu_control=000.
- ADD: imem_rdata=32'h002081B3, valid in first FETCH cycle → rs_1=1, rs_2=2, rd_0=3, alu_control=010, sel_imm=0; write_rb high only in cycle 4; pc 0→4.
- SUB: 32'h407302B3 → rs_1=6, rs_2=7, rd_0=5, alu_control=110, one write_rb pulse.
- ADDI: 32'hFFB00093 → rs_1=0, rd_0=1, sel_imm=1, imm=32'hFFFFFFFB, alu_control=010.
- Memory wait: imem_valid delayed 3 cycles after imem_req → imem_req held high 4 cycles with imem_addr constant; instruction completes in 7 cycles; rdata presented while valid=0 is ignored.
- Illegal/reset: 32'hFFFFFFFF → illegal=1 permanently, no write_rb, pc frozen; then rst for 1 cycle → state FETCH, pc=RESET_PC, illegal=0.
